// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a valid/ready handshake and an optional 2-entry skid buffer.
// The stage can be placed between any two core stages.
//
// Parameters
//   DATA_W   : datapath payload width. The payload is zero while the stage is empty.
//   CTRL_W   : control payload width.
//   CTRL_NOP : control value presented while the stage is empty (the bubble encoding).
//   SKID     : 1 = main register plus skid register, in_ready comes from a register.
//              0 = single register, in_ready is combinational from out_ready.
//   STAT_W   : width of the saturating stall counter.
//
// Ports
//   clk, rst             : clock and synchronous active-high reset.
//   flush                : kills all held entries and any beat accepted in the same cycle.
//   in_valid / in_ready  : upstream handshake.
//   in_data / in_ctrl    : upstream payload.
//   out_valid / out_ready: downstream handshake.
//   out_data / out_ctrl  : presented payload (0 / CTRL_NOP when out_valid=0).
//   occupancy            : number of held entries (0..2).
//   stall_cnt            : cycles with out_valid=1 and out_ready=0, saturating.
module pipe_skid_stage #(
  parameter int unsigned        DATA_W   = 64,
  parameter int unsigned        CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
  parameter int unsigned        SKID     = 1,
  parameter int unsigned        STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [STAT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [STAT_W-1:0] stall_q, stall_d;
  logic              accept, retire;

  assign out_valid = (state_q != StEmpty);

  // With the skid register in_ready depends only on state, so back-pressure is not a
  // combinational path between stages. Without it, a retiring beat frees the slot in-cycle.
  if (SKID != 0) begin : g_skid_ready
    assign in_ready = (state_q != StFull);
  end else begin : g_comb_ready
    assign in_ready = (state_q == StEmpty) | out_ready;
  end

  assign accept = in_valid & in_ready;
  assign retire = out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d  = StOne;
          m_data_d = in_data;
          m_ctrl_d = in_ctrl;
        end
      end
      StOne: begin
        if (accept && retire) begin
          m_data_d = in_data;
          m_ctrl_d = in_ctrl;
        end else if (retire) begin
          state_d  = StEmpty;
          m_data_d = '0;
          m_ctrl_d = CTRL_NOP;
        end else if (accept && (SKID != 0)) begin
          // Downstream is stalled: park the new beat behind M to keep FIFO order.
          state_d  = StFull;
          s_data_d = in_data;
          s_ctrl_d = in_ctrl;
        end
      end
      StFull: begin
        if (retire) begin
          state_d  = StOne;
          m_data_d = s_data_q;
          m_ctrl_d = s_ctrl_q;
          s_data_d = '0;
          s_ctrl_d = CTRL_NOP;
        end
      end
      default: begin
        state_d  = StEmpty;
        m_data_d = '0;
        m_ctrl_d = CTRL_NOP;
        s_data_d = '0;
        s_ctrl_d = CTRL_NOP;
      end
    endcase

    // Flush wins over the handshake: everything held or accepted this cycle becomes a bubble.
    if (flush) begin
      state_d  = StEmpty;
      m_data_d = '0;
      m_ctrl_d = CTRL_NOP;
      s_data_d = '0;
      s_ctrl_d = CTRL_NOP;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {STAT_W{1'b1}})) begin
      stall_d = stall_q + STAT_W'(1);
    end
  end

  always_comb begin
    occupancy = 2'd0;
    unique case (state_q)
      StEmpty: occupancy = 2'd0;
      StOne:   occupancy = 2'd1;
      StFull:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StEmpty;
      m_data_q <= '0;
      m_ctrl_q <= CTRL_NOP;
      s_data_q <= '0;
      s_ctrl_q <= CTRL_NOP;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      m_ctrl_q <= m_ctrl_d;
      s_data_q <= s_data_d;
      s_ctrl_q <= s_ctrl_d;
      stall_q  <= stall_d;
    end
  end

  // M is cleared on every transition to empty, so the outputs are a bubble without gating.
  assign out_data  = m_data_q;
  assign out_ctrl  = m_ctrl_q;
  assign stall_cnt = stall_q;

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised successor of the fixed-field EX/MEM-style pipeline register.
- Generic data/control payload with a valid/ready handshake and an optional 2-entry skid buffer, so back-pressure does not need a combinational stall path across stages.
- Flush converts contents to a NOP bubble with programmable control encoding.
- Saturating stall counter for benchmarking.
- Sits between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 64, width of datapath payload (results, operands, PC); zeroed on flush/reset.
- CTRL_W, 8, width of control payload (write enables, load/store type, rd).
- CTRL_NOP, {CTRL_W{1'b0}}, control value driven while empty, after flush and after reset.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- STAT_W, 16, width of stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous kill of all held entries and the current input.
- in_valid  in  1  upstream offers a beat.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  upstream datapath payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  stage presents a beat.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  presented datapath payload.
- out_ctrl  out  CTRL_W  presented control payload; CTRL_NOP when out_valid=0.
- occupancy  out  2  number of held entries (0..2; max 1 when SKID=0).
- stall_cnt  out  STAT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (synchronous, highest priority):
  - out_valid=0, out_data=0, out_ctrl=CTRL_NOP, occupancy=0, stall_cnt=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-transfer drops all held beats.
- Handshake: accept when in_valid&in_ready; retire when out_valid&out_ready.
  - While out_valid=1 and out_ready=0, out_data and out_ctrl are held stable.
  - in_valid/in_data are not required to stay stable when in_ready=0.
- Latency: 1 cycle. A beat accepted at edge N appears on out_* after edge N when the stage was empty or retiring.
- SKID=1 state machine (main register M, skid register S):
  - EMPTY:
    - accept -> ONE (beat loaded into M).
  - ONE:
    - accept & retire -> ONE (M reloaded).
    - retire only -> EMPTY.
    - accept only -> FULL (beat into S).
    - neither -> ONE.
  - FULL:
    - retire -> ONE (S moves to M).
    - no retire -> FULL.
  - in_ready = !FULL, a register output with no combinational path from out_ready.
  - FULL + retire: in_ready is 0 that cycle, so no simultaneous accept.
  - Ordering is strictly FIFO; S never bypasses M.
- SKID=0:
  - Single register M; in_ready = !out_valid | out_ready (combinational).
  - States are EMPTY and ONE only; occupancy never exceeds 1.
- Throughput: one beat per cycle sustained when out_ready=1 continuously (both modes).
- Flush:
  - At the edge where flush=1 and rst=0, all entries are invalidated and a beat accepted that cycle is dropped.
  - Next cycle: out_valid=0, out_data=0, out_ctrl=CTRL_NOP, occupancy=0.
  - A retire handshake in the flush cycle still counts as delivered to downstream.
  - in_ready stays per normal rules during flush (1 unless FULL).
  - stall_cnt is not cleared by flush.
- Empty output: whenever out_valid=0, out_data=0 and out_ctrl=CTRL_NOP, giving downstream a bubble without extra gating.
- stall_cnt:
  - Increments by 1 on every cycle with out_valid=1 & out_ready=0.
  - Saturates at 2^STAT_W-1 with no wrap.
  - Cleared only by rst.
- occupancy equals the count of valid entries after each edge (EMPTY=0, ONE=1, FULL=2).

Test Plan:
- Reset/bubble: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=CTRL_NOP, out_data=0, stall_cnt=0, in_ready=1 after release.
- Streaming, SKID=1: in_valid=1 with data 1..10 and out_ready=1 constantly -> out_data 1..10 in order on consecutive cycles, 1-cycle latency, occupancy=1 throughout, stall_cnt=0.
- Back-pressure/skid: stream A, B, C, drop out_ready for 3 cycles after A appears:
  - occupancy reaches 2 and in_ready=0; C is not accepted until space frees.
  - out_data holds A stable; stall_cnt=3.
  - After out_ready returns, output is A, B, C with no loss or duplication.
- Flush while FULL, with an offered beat D: next cycle out_valid=0, out_ctrl=CTRL_NOP, occupancy=0; D never appears; stall_cnt unchanged.
- SKID=0 build: same back-pressure pattern -> in_ready follows out_ready combinationally while out_valid=1, occupancy max 1, order preserved.
- Saturation with STAT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15; rst returns it to 0.
